// File: rtl/ula_controle_multiciclo.sv
// Multicycle MIPS control unit: sequences one instruction over 3-5 cycles and
// drives the ULA operation code, operand selects and datapath write enables.
module ula_controle_multiciclo #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic [2:0]         ula_control,
    output logic               ula_src_a,
    output logic [1:0]         ula_src_b,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 0,
        DECODE   = 1,
        MEMADR   = 2,
        MEMREAD  = 3,
        MEMWB    = 4,
        MEMWRITE = 5,
        EXECUTE  = 6,
        ALUWB    = 7,
        BRANCH   = 8,
        ADDIEX   = 9,
        ADDIWB   = 10,
        JUMP     = 11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    logic   pc_write, branch;
    logic   mem_write_raw, ir_write_raw, reg_write_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = FETCH;
        ula_control   = 3'b010;
        ula_src_a     = 1'b0;
        ula_src_b     = 2'b00;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        case (state_q)
            FETCH: begin
                ula_src_b    = 2'b01;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                state_d      = DECODE;
            end
            DECODE: begin
                ula_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = MEMREAD;
                else if (opcode == OP_SW) state_d = MEMWRITE;
            end
            MEMREAD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTE: begin
                ula_src_a = 1'b1;
                state_d   = ALUWB;
                // Unsupported funct keeps ADD on the bus and skips writeback.
                case (funct)
                    6'b100000: ula_control = 3'b010;
                    6'b100010: ula_control = 3'b110;
                    6'b100100: ula_control = 3'b000;
                    6'b100101: ula_control = 3'b001;
                    6'b101010: ula_control = 3'b111;
                    default:   state_d     = FETCH;
                endcase
            end
            ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            BRANCH: begin
                ula_src_a   = 1'b1;
                ula_control = 3'b110;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            ADDIEX: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: reg_write_raw = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Enables are gated by reset so the reset cycle never writes anything.
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign pc_en     = (pc_write | (branch & zero)) & ~reset;
    assign state     = state_q;

endmodule

// File: tb/tb_ula_controle_multiciclo.sv
// Scoreboard bench: expected per-cycle outputs come from an instruction-level
// model and are checked by an independent negedge monitor.
module tb_ula_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic [2:0] ula_control;
    logic       ula_src_a;
    logic [1:0] ula_src_b, pc_src;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic [3:0] state;

    ula_controle_multiciclo #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .ula_control(ula_control), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       a;
        logic [1:0] b;
        logic [1:0] pcs;
        logic       pc_en;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t actual();
        exp_t r;
        r.st = state; r.alu = ula_control; r.a = ula_src_a; r.b = ula_src_b;
        r.pcs = pc_src; r.pc_en = pc_en; r.iord = iord; r.mw = mem_write;
        r.irw = ir_write; r.rw = reg_write; r.rd = reg_dst; r.m2r = mem_to_reg;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: ALU op for an R-type funct, or -1 when unsupported.
    function automatic int rtype_op(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    // Outputs of one step of an instruction, named by the state it occupies.
    function automatic exp_t step_outs(input int s, input logic [5:0] fn, input logic z);
        exp_t e = '0;
        e.st  = 4'(s);
        e.alu = 3'b010;
        case (s)
            0:  begin e.b = 2'b01; e.irw = 1; e.pc_en = 1; end
            1:  e.b = 2'b11;
            2:  begin e.a = 1; e.b = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.rw = 1; e.m2r = 1; end
            5:  begin e.iord = 1; e.mw = 1; end
            6:  begin e.a = 1; if (rtype_op(fn) >= 0) e.alu = 3'(rtype_op(fn)); end
            7:  begin e.rw = 1; e.rd = 1; end
            8:  begin e.a = 1; e.alu = 3'b110; e.pcs = 2'b01; e.pc_en = z; end
            9:  begin e.a = 1; e.b = 2'b10; end
            10: e.rw = 1;
            11: begin e.pcs = 2'b10; e.pc_en = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Sequence of states an instruction visits from FETCH back to FETCH.
    task automatic build_path(input logic [5:0] op, input logic [5:0] fn, output int p[$]);
        p = {0, 1};
        case (op)
            6'b100011: p = {p, 2, 3, 4};
            6'b101011: p = {p, 2, 5};
            6'b000000: begin p.push_back(6); if (rtype_op(fn) >= 0) p.push_back(7); end
            6'b000100: p.push_back(8);
            6'b001000: p = {p, 9, 10};
            6'b000010: p.push_back(11);
            default: ;
        endcase
    endtask

    // Called just after a rising edge that left the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int p[$];
        build_path(op, fn, p);
        foreach (p[i]) exp_q.push_back(step_outs(p[i], fn, z));
        opcode = op; funct = fn; zero = z;
        $display("instr op=%b funct=%b zero=%b cycles=%0d", op, fn, z, p.size());
        repeat (p.size()) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("cycle st=%0d op=%b fn=%b", e.st, opcode, funct),
                  32'(actual()), 32'(e));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000,
                                      6'b000100, 6'b001000, 6'b000010};
    localparam logic [5:0] FNS [5] = '{6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b101010};

    initial begin
        logic [5:0] op, fn;
        int         waited;
        reset = 1'b1; opcode = 6'b101011; funct = '0; zero = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset state", 32'(state), 0);
        check("reset enables", {28'd0, mem_write, reg_write, ir_write, pc_en}, 0);
        @(posedge clk);
        @(negedge clk);
        check("reset2 enables", {28'd0, mem_write, reg_write, ir_write, pc_en}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (FNS[i]) run_instr(6'b000000, FNS[i], 1'b0);
        run_instr(6'b100011, 6'd0, 1'b0);
        run_instr(6'b101011, 6'd0, 1'b1);
        run_instr(6'b000100, 6'd0, 1'b1);
        run_instr(6'b000100, 6'd0, 1'b0);
        run_instr(6'b001000, 6'd0, 1'b0);
        run_instr(6'b000010, 6'd0, 1'b0);
        run_instr(6'b111111, 6'd0, 1'b1);
        run_instr(6'b000000, 6'b000111, 1'b0);

        // Reset while a store is in its write cycle.
        opcode = 6'b101011; funct = '0; zero = 1'b0;
        waited = 0;
        while (state !== 4'd5 && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        check("reach MEMWRITE", 32'(state), 5);
        reset = 1'b1;
        @(negedge clk);
        check("midop mem_write", 32'(mem_write), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midop state", 32'(state), 0);
        check("midop ir_write", 32'(ir_write), 1);
        @(posedge clk);
        #1;
        // State is DECODE now; finish this instruction as an unknown opcode.
        opcode = 6'b111110;
        @(posedge clk);
        #1;

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom));
        end

        @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
